// File: rtl/transport_controller_if.sv
// ----------------------------------------------------------------------------
// transport_controller_if
// Groups the transport request inputs, I2S word-select clocks, store/load
// handshake and status outputs of transport_controller.
//   master : user/test side; drives rec_req, play_req, stop_req, ws_rx,
//            ws_tx and sl_busy; observes everything else.
//   slave  : the controller; drives store_req, load_req, wr_en, rd_en,
//            mute, rec_len, play_pos and state.
// ----------------------------------------------------------------------------
interface transport_controller_if #(
    parameter int unsigned CNT_WIDTH = 20
);
    logic                 rec_req;
    logic                 play_req;
    logic                 stop_req;
    logic                 ws_rx;
    logic                 ws_tx;
    logic                 sl_busy;
    logic                 store_req;
    logic                 load_req;
    logic                 wr_en;
    logic                 rd_en;
    logic                 mute;
    logic [CNT_WIDTH-1:0] rec_len;
    logic [CNT_WIDTH-1:0] play_pos;
    logic [2:0]           state;

    modport master (
        output rec_req, play_req, stop_req, ws_rx, ws_tx, sl_busy,
        input  store_req, load_req, wr_en, rd_en, mute, rec_len, play_pos, state
    );

    modport slave (
        input  rec_req, play_req, stop_req, ws_rx, ws_tx, sl_busy,
        output store_req, load_req, wr_en, rd_en, mute, rec_len, play_pos, state
    );
endinterface

// File: rtl/transport_controller.sv
// ----------------------------------------------------------------------------
// transport_controller
// Record/playback sequencer for the single-track loop path. Converts
// rec/play/stop requests into store/load request levels and per-frame
// write/read strobes aligned to I2S frame starts (falling edge of ws).
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset (release expected synchronous to clk)
//   bus  : transport_controller_if.slave
//          in : rec_req, play_req, stop_req, ws_rx, ws_tx (async), sl_busy
//          out: store_req, load_req, wr_en, rd_en, mute, rec_len, play_pos,
//               state (IDLE=0 REC_ARM=1 REC=2 FLUSH=3 PLAY_ARM=4 PLAY=5)
// Build option:
//   LOOP_PLAYBACK_EN : defined -> playback wraps to frame 0 at end of take;
//                      undefined -> playback stops and returns to IDLE.
// ----------------------------------------------------------------------------
module transport_controller #(
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH   = 20,
    parameter int unsigned MAX_SAMPLES = 2**20 - 1
) (
    input logic                   clk,
    input logic                   rst,
    transport_controller_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REC_ARM  = 3'd1,
        REC      = 3'd2,
        FLUSH    = 3'd3,
        PLAY_ARM = 3'd4,
        PLAY     = 3'd5
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_SAMPLES);

    // No audio datapath here; WORD_WIDTH only keeps the parameter list
    // aligned with the rest of the audio path.
    logic unused_word_width;
    assign unused_word_width = (WORD_WIDTH == 0);

    // Synchronisers: bit 0 rec, 1 play, 2 stop, 3 ws_rx, 4 ws_tx
    logic [4:0] async_in, meta_q, sync_q, prev_q;
    logic       rec_ev, play_ev, stop_ev, rx_fs, tx_fs;

    assign async_in = {bus.ws_tx, bus.ws_rx, bus.stop_req, bus.play_req, bus.rec_req};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rec_ev  =  sync_q[0] & ~prev_q[0];
    assign play_ev =  sync_q[1] & ~prev_q[1];
    assign stop_ev =  sync_q[2] & ~prev_q[2];
    assign rx_fs   = ~sync_q[3] &  prev_q[3];
    assign tx_fs   = ~sync_q[4] &  prev_q[4];

    state_e               state_q, state_d;
    logic                 store_req_q, store_req_d;
    logic                 load_req_q, load_req_d;
    logic                 wr_en_q, wr_en_d;
    logic                 rd_en_q, rd_en_d;
    logic                 mute_q, mute_d;
    logic [CNT_WIDTH-1:0] rec_cnt_q, rec_cnt_d;
    logic [CNT_WIDTH-1:0] rec_len_q, rec_len_d;
    logic [CNT_WIDTH-1:0] play_pos_q, play_pos_d;
    logic [CNT_WIDTH-1:0] rec_cnt_nx, last_idx;

    // Recording count including a frame start in this cycle
    assign rec_cnt_nx = rx_fs ? rec_cnt_q + CNT_ONE : rec_cnt_q;
    assign last_idx   = rec_len_q - CNT_ONE;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            store_req_q <= 1'b0;
            load_req_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            mute_q      <= 1'b1;
            rec_cnt_q   <= '0;
            rec_len_q   <= '0;
            play_pos_q  <= '0;
        end else begin
            state_q     <= state_d;
            store_req_q <= store_req_d;
            load_req_q  <= load_req_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            mute_q      <= mute_d;
            rec_cnt_q   <= rec_cnt_d;
            rec_len_q   <= rec_len_d;
            play_pos_q  <= play_pos_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rec_ev)                             state_d = REC_ARM;
                else if (play_ev && (rec_len_q != '0))  state_d = PLAY_ARM;
            end
            REC_ARM: begin
                if (stop_ev)     state_d = FLUSH;
                else if (rx_fs)  state_d = REC;
            end
            REC: begin
                if (stop_ev || (rec_cnt_nx == CNT_MAX)) state_d = FLUSH;
            end
            FLUSH: begin
                if (!bus.sl_busy) state_d = IDLE;
            end
            PLAY_ARM: begin
                if (stop_ev)     state_d = IDLE;
                else if (tx_fs)  state_d = PLAY;
            end
            PLAY: begin
                if (stop_ev) state_d = IDLE;
`ifndef LOOP_PLAYBACK_EN
                else if (tx_fs && (play_pos_q == last_idx)) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / counter next values
    always_comb begin
        store_req_d = (state_d == REC_ARM) || (state_d == REC);
        load_req_d  = (state_d == PLAY_ARM) || (state_d == PLAY);
        mute_d      = (state_d != PLAY);
        wr_en_d     = (state_q == REC) && rx_fs;
        rd_en_d     = (state_q == PLAY) && tx_fs;
        rec_cnt_d   = rec_cnt_q;
        rec_len_d   = rec_len_q;
        play_pos_d  = play_pos_q;
        case (state_q)
            REC_ARM: begin
                if (rx_fs) rec_cnt_d = '0;
            end
            REC: begin
                rec_cnt_d = rec_cnt_nx;
                if (state_d == FLUSH) rec_len_d = rec_cnt_nx;
            end
            PLAY_ARM: begin
                if (tx_fs) play_pos_d = '0;
            end
            PLAY: begin
                // play_pos advances the cycle after the strobe so it names the
                // frame being read while rd_en is high. Without looping the FSM
                // has already left PLAY at the last frame, so it holds there.
                if (rd_en_q)
                    play_pos_d = (play_pos_q == last_idx) ? '0 : play_pos_q + CNT_ONE;
            end
            default: ;
        endcase
    end

    assign bus.state     = state_q;
    assign bus.store_req = store_req_q;
    assign bus.load_req  = load_req_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.mute      = mute_q;
    assign bus.rec_len   = rec_len_q;
    assign bus.play_pos  = play_pos_q;

endmodule

// File: tb/tb_transport_controller.sv
module tb_transport_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    transport_controller_if #(.CNT_WIDTH(20)) bus ();

    transport_controller #(
        .WORD_WIDTH (8),
        .CNT_WIDTH  (20),
        .MAX_SAMPLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int passes = 0;
    int wr_seen = 0;
    int rd_seen = 0;
    int exp_wr[$];
    int exp_rd[$];
    logic wr_prev = 1'b0;
    logic rd_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Scoreboard monitor: strobes sampled on the falling edge
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_seen++;
            check("wr_1cyc", {31'd0, wr_prev}, 32'd0);
            if (exp_wr.size() != 0) check("wr_idx", wr_seen, exp_wr.pop_front());
            else check("wr_unexpected", {31'd0, bus.wr_en}, 32'd0);
        end
        if (bus.rd_en === 1'b1) begin
            rd_seen++;
            check("rd_1cyc", {31'd0, rd_prev}, 32'd0);
            if (exp_rd.size() != 0) check("rd_pos", bus.play_pos, exp_rd.pop_front());
            else check("rd_unexpected", {31'd0, bus.rd_en}, 32'd0);
        end
        wr_prev = bus.wr_en;
        rd_prev = bus.rd_en;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_rx();
        bus.ws_rx = 1'b1; cyc(4);
        bus.ws_rx = 1'b0; cyc(4);
    endtask

    task automatic frame_tx();
        bus.ws_tx = 1'b1; cyc(4);
        bus.ws_tx = 1'b0; cyc(4);
    endtask

    // which: 0 rec, 1 play, 2 stop
    task automatic pulse(input int which);
        case (which)
            0: bus.rec_req = 1'b1;
            1: bus.play_req = 1'b1;
            default: bus.stop_req = 1'b1;
        endcase
        cyc(4);
        bus.rec_req = 1'b0; bus.play_req = 1'b0; bus.stop_req = 1'b0;
        cyc(4);
    endtask

    initial begin
        bus.rec_req = 1'b0; bus.play_req = 1'b0; bus.stop_req = 1'b0;
        bus.ws_rx = 1'b0; bus.ws_tx = 1'b0; bus.sl_busy = 1'b0;
        cyc(3);
        @(negedge clk) rst = 1'b0;
        cyc(2);

        // Reset values
        check("rst_state", bus.state, 0);
        check("rst_store", bus.store_req, 0);
        check("rst_load", bus.load_req, 0);
        check("rst_mute", bus.mute, 1);
        check("rst_reclen", bus.rec_len, 0);
        check("rst_playpos", bus.play_pos, 0);

        // Play with empty take is ignored
        pulse(1);
        check("empty_play_state", bus.state, 0);
        check("empty_play_load", bus.load_req, 0);
        check("empty_play_mute", bus.mute, 1);

        // Request latency: 3 edges from pin to registered state
        bus.rec_req = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("lat_2edges", bus.state, 0);
        @(posedge clk); #1;
        check("lat_3edges", bus.state, 1);
        cyc(3);
        bus.rec_req = 1'b0;
        cyc(4);
        check("arm_store", bus.store_req, 1);

        // Reset mid-record after 5 frames
        frame_rx();
        check("rec_state", bus.state, 2);
        for (int i = 0; i < 5; i++) begin
            exp_wr.push_back(i + 1);
            frame_rx();
        end
        #2 rst = 1'b1;
        #1;
        check("async_state", bus.state, 0);
        check("async_store", bus.store_req, 0);
        check("async_mute", bus.mute, 1);
        check("async_reclen", bus.rec_len, 0);
        @(negedge clk) rst = 1'b0;
        cyc(2);
        check("postrst_state", bus.state, 0);
        check("t1_wr_count", wr_seen, 5);
        check("t1_wr_drained", exp_wr.size(), 0);

        // MAX_SAMPLES=16 auto-stop, FLUSH held by sl_busy
        wr_seen = 0;
        bus.sl_busy = 1'b1;
        pulse(0);
        frame_rx();
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp_wr.push_back(i + 1);
            frame_rx();
        end
        check("max_state", bus.state, 3);
        check("max_reclen", bus.rec_len, 16);
        check("max_store", bus.store_req, 0);
        check("max_wr_count", wr_seen, 16);
        check("max_wr_drained", exp_wr.size(), 0);
        cyc(50);
        check("flush_hold", bus.state, 3);
        bus.sl_busy = 1'b0;
        cyc(3);
        check("flush_exit", bus.state, 0);

        // Stop coinciding with the 8th frame start
        wr_seen = 0;
        bus.sl_busy = 1'b1;
        pulse(0);
        frame_rx();
        for (int i = 0; i < 7; i++) begin
            exp_wr.push_back(i + 1);
            frame_rx();
        end
        exp_wr.push_back(8);
        bus.ws_rx = 1'b1; cyc(4);
        bus.ws_rx = 1'b0; bus.stop_req = 1'b1; cyc(4);
        bus.stop_req = 1'b0; cyc(4);
        check("coinc_wr_count", wr_seen, 8);
        check("coinc_reclen", bus.rec_len, 8);
        check("coinc_state", bus.state, 3);
        bus.sl_busy = 1'b0;
        cyc(3);
        check("coinc_idle", bus.state, 0);

        // Record 4 frames, then play 10 tx frames
        wr_seen = 0;
        pulse(0);
        frame_rx();
        for (int i = 0; i < 4; i++) begin
            exp_wr.push_back(i + 1);
            frame_rx();
        end
        pulse(2);
        cyc(3);
        check("take4_reclen", bus.rec_len, 4);
        check("take4_idle", bus.state, 0);
        pulse(1);
        check("parm_state", bus.state, 4);
        check("parm_load", bus.load_req, 1);
        check("parm_store", bus.store_req, 0);
        check("parm_mute", bus.mute, 1);
        frame_tx();
        check("play_state", bus.state, 5);
        check("play_mute", bus.mute, 0);
        check("play_pos0", bus.play_pos, 0);
        for (int i = 0; i < 10; i++) begin
`ifdef LOOP_PLAYBACK_EN
            exp_rd.push_back(i % 4);
`else
            if (i < 4) exp_rd.push_back(i);
`endif
            frame_tx();
        end
        check("rd_drained", exp_rd.size(), 0);
`ifdef LOOP_PLAYBACK_EN
        check("loop_rd_count", rd_seen, 10);
        check("loop_state", bus.state, 5);
        check("loop_pos", bus.play_pos, 2);
        check("loop_mute", bus.mute, 0);
        pulse(2);
        check("loop_stop_state", bus.state, 0);
        check("loop_stop_mute", bus.mute, 1);
`else
        check("end_rd_count", rd_seen, 4);
        check("end_state", bus.state, 0);
        check("end_mute", bus.mute, 1);
        check("end_pos", bus.play_pos, 3);
        check("end_load", bus.load_req, 0);
`endif

        // Simultaneous rec and play: rec wins
        bus.rec_req = 1'b1; bus.play_req = 1'b1;
        cyc(5);
        check("both_state", bus.state, 1);
        check("both_store", bus.store_req, 1);
        check("both_load", bus.load_req, 0);
        bus.rec_req = 1'b0; bus.play_req = 1'b0;
        cyc(3);
        pulse(2);
        cyc(3);
        check("both_stop_idle", bus.state, 0);
        check("final_wr_drained", exp_wr.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
